// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit multiply/divide unit producing HI/LO results
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mul_enable,
   input  logic             div_enable,
   input  logic             mul_signed,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_by_zero
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // magnitude of operand_b: the multiplicand addend or the divisor
   logic [WIDTH-1:0]   mag_b_q, mag_b_d;
   // raw dividend, returned as the remainder on a zero divisor
   logic [WIDTH-1:0]   raw_a_q, raw_a_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               is_div_q, is_div_d;
   logic               b_zero_q, b_zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dbz_q, dbz_d;

   logic               start;
   logic               op_signed;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_top;
   logic               div_ge;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic               last_iter;

   // Operand conditioning at start: mul has priority over div when both are requested
   always_comb begin
      start     = mul_enable | div_enable;
      op_signed = mul_enable ? mul_signed : div_signed;
      a_neg     = op_signed & operand_a[WIDTH-1];
      b_neg     = op_signed & operand_b[WIDTH-1];
      mag_a     = a_neg ? ('0 - operand_a) : operand_a;
      mag_b     = b_neg ? ('0 - operand_b) : operand_b;
   end

   // One shift-add multiply step and one restoring shift-subtract divide step
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      // remainder shifted left with the next dividend bit; it is always below 2*divisor,
      // so when it is >= divisor the difference fits in WIDTH bits
      div_top   = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge    = (div_top >= {1'b0, mag_b_q});
      div_sub   = acc_q[2*WIDTH-2:WIDTH-1] - mag_b_q;
      div_next  = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                         : {acc_q[2*WIDTH-2:0], 1'b0};
      prod_neg  = '0 - acc_q;
      quot      = acc_q[WIDTH-1:0];
      rem       = acc_q[2*WIDTH-1:WIDTH];
      last_iter = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // Next-state, datapath updates and the combinational stall request
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mag_b_d   = mag_b_q;
      raw_a_d   = raw_a_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      is_div_d  = is_div_q;
      b_zero_d  = b_zero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = dbz_q;
      busy      = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy = start;
            if (start && !flush) begin
               cnt_d     = '0;
               acc_d     = {{WIDTH{1'b0}}, mag_a};
               mag_b_d   = mag_b;
               raw_a_d   = operand_a;
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               is_div_d  = ~mul_enable;
               b_zero_d  = (operand_b == '0);
               state_d   = mul_enable ? S_MUL : S_DIV;
            end
         end
         S_MUL: begin
            busy = 1'b1;
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = mul_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_iter) begin
                  state_d = S_FIX;
               end
            end
         end
         S_DIV: begin
            busy = 1'b1;
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = div_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_iter) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            busy  = 1'b1;
            cnt_d = '0;
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
               if (!is_div_q) begin
                  {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
                  dbz_d        = 1'b0;
               end else if (b_zero_q) begin
                  hi_d  = raw_a_q;
                  lo_d  = '1;
                  dbz_d = 1'b1;
               end else begin
                  hi_d  = neg_rem_q ? ('0 - rem) : rem;
                  lo_d  = neg_res_q ? ('0 - quot) : quot;
                  dbz_d = 1'b0;
               end
            end
         end
         S_DONE: begin
            // enables seen here belong to the completing instruction
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mag_b_q   <= '0;
         raw_a_q   <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_div_q  <= 1'b0;
         b_zero_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mag_b_q   <= mag_b_d;
         raw_a_q   <= raw_a_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         is_div_q  <= is_div_d;
         b_zero_q  <= b_zero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_q     <= dbz_d;
      end
   end

   // Completion outputs
   always_comb begin
      done        = (state_q == S_DONE);
      div_by_zero = (state_q == S_DONE) & dbz_q;
      hi_out      = hi_q;
      lo_out      = lo_q;
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mul_enable = 1'b0;
   logic        div_enable = 1'b0;
   logic        mul_signed = 1'b0;
   logic        div_signed = 1'b0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_by_zero;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [64:0] sb_q[$];
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mul_enable (mul_enable),
      .div_enable (div_enable),
      .mul_signed (mul_signed),
      .div_signed (div_signed),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .flush      (flush),
      .busy       (busy),
      .done       (done),
      .hi_out     (hi_out),
      .lo_out     (lo_out),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [64:0] ref_model(input bit is_div, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic [31:0] q;
      logic [31:0] r;
      if (!is_div) begin
         if (sgn) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         else     p = {32'd0, a} * {32'd0, b};
         return {1'b0, p};
      end
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
      if (sgn) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {1'b0, r, q};
   endfunction

   // exp = {div_by_zero, hi, lo}
   task automatic run_op(input bit is_div, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit both, input bit hold, input logic [64:0] exp);
      int          n;
      logic [64:0] e;
      @(negedge clk);
      mul_enable = !is_div || both;
      div_enable = is_div || both;
      mul_signed = sgn;
      div_signed = sgn;
      operand_a  = a;
      operand_b  = b;
      sb_q.push_back(exp);
      #1 check_eq("busy_issue", busy, 1);
      @(posedge clk);
      #1;
      operand_a = $urandom;
      operand_b = $urandom;
      if (!hold) begin
         mul_enable = 1'b0;
         div_enable = 1'b0;
      end
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         check_eq("busy_iter", busy, 1);
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("latency", n, 34);
      check_eq("done", done, 1);
      check_eq("busy_done", busy, 0);
      check_eq("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check_eq("hi", hi_out, e[63:32]);
         check_eq("lo", lo_out, e[31:0]);
         check_eq("dbz", div_by_zero, e[64]);
         last_hi = e[63:32];
         last_lo = e[31:0];
      end
      @(posedge clk);
      #1;
      mul_enable = 1'b0;
      div_enable = 1'b0;
      check_eq("done_pulse", done, 0);
      check_eq("dbz_pulse", div_by_zero, 0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check_eq("idle_busy", busy, 0);
         check_eq("idle_done", done, 0);
      end
      check_eq("hi_hold", hi_out, last_hi);
      check_eq("lo_hold", lo_out, last_lo);
   endtask

   task automatic no_done_window(input string tag, input int cycles);
      int seen;
      seen = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen++;
      end
      check_eq(tag, seen, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          rd;
      bit          rs;
      logic [31:0] ra;
      logic [31:0] rb;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_hi", hi_out, 0);
      check_eq("rst_lo", lo_out, 0);
      check_eq("rst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
      run_op(0, 1, 32'hFFFF_FFFD, 32'd7, 0, 0, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
      run_op(1, 1, 32'hFFFF_FFF9, 32'd2, 0, 0, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op(1, 0, 32'd100, 32'd7, 0, 0, {1'b0, 32'd2, 32'd14});
      run_op(1, 0, 32'h1234_5678, 32'd0, 0, 0, {1'b1, 32'h1234_5678, 32'hFFFF_FFFF});
      run_op(1, 1, 32'h8000_0001, 32'd0, 0, 0, {1'b1, 32'h8000_0001, 32'hFFFF_FFFF});
      run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, {1'b0, 32'd0, 32'h8000_0000});
      // both enables: multiply wins
      run_op(0, 0, 32'd100, 32'd7, 1, 0, {1'b0, 32'd0, 32'd700});
      // enables held through DONE must not start a second operation
      run_op(1, 0, 32'd1000, 32'd3, 0, 1, {1'b0, 32'd1, 32'd333});
      no_done_window("hold_no_second", 40);

      // flush at iteration 10
      @(negedge clk);
      mul_enable = 1'b1;
      mul_signed = 1'b0;
      operand_a  = 32'hDEAD_BEEF;
      operand_b  = 32'h1234;
      @(posedge clk);
      #1;
      mul_enable = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      #1 check_eq("flush_busy_before", busy, 1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      #1;
      check_eq("flush_busy_after", busy, 0);
      check_eq("flush_done", done, 0);
      no_done_window("flush_no_done", 40);
      check_eq("flush_hi", hi_out, last_hi);
      check_eq("flush_lo", lo_out, last_lo);

      // flush in IDLE blocks a simultaneous start
      @(negedge clk);
      flush      = 1'b1;
      div_enable = 1'b1;
      operand_a  = 32'd50;
      operand_b  = 32'd5;
      @(posedge clk);
      #1;
      flush      = 1'b0;
      div_enable = 1'b0;
      #1 check_eq("flush_idle_busy", busy, 0);
      no_done_window("flush_idle_no_done", 40);

      // reset at iteration 20
      @(negedge clk);
      div_enable = 1'b1;
      div_signed = 1'b0;
      operand_a  = 32'd999;
      operand_b  = 32'd4;
      @(posedge clk);
      #1;
      div_enable = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy", busy, 0);
      check_eq("arst_done", done, 0);
      check_eq("arst_hi", hi_out, 0);
      check_eq("arst_lo", lo_out, 0);
      check_eq("arst_dbz", div_by_zero, 0);
      last_hi = '0;
      last_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      no_done_window("arst_no_done", 40);

      for (int i = 0; i < 8; i++) begin
         rd = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         run_op(rd, rs, ra, rb, 0, 0, ref_model(rd, rs, ra, rb));
      end

      check_eq("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
